// File: rtl/seg7_scan_controller_pkg.sv
// Shared state encodings and hex segment table for the 7-segment scan controller.
package seg7_scan_controller_pkg;

  typedef enum logic [1:0] {
    SCAN_BLANK0 = 2'd0,
    SCAN_SHOW0  = 2'd1,
    SCAN_BLANK1 = 2'd2,
    SCAN_SHOW1  = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-high {g,f,e,d,c,b,a} patterns; element n is hex digit n
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high {g..a} segment pattern.
module seg7_hex_decode
  import seg7_scan_controller_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_pattern
);

  assign o_pattern = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg7_scan_controller.sv
// Scans an 8-bit value onto a dual-digit common-segment display with a blanked
// dead time per slot; accepted values wait in a pending register until frame start.
module seg7_scan_controller
  import seg7_scan_controller_pkg::*;
#(
  parameter int REFRESH_DIV = 25000,
  parameter int DEAD_CYCLES = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value_in,
  input  logic       value_valid,
  output logic       value_ready,
  input  logic [1:0] blank,
  output logic       seg_a,
  output logic       seg_b,
  output logic       seg_c,
  output logic       seg_d,
  output logic       seg_e,
  output logic       seg_f,
  output logic       seg_g,
  output logic       seg_select,
  output logic       frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

  generate
    if (REFRESH_DIV < 2 || REFRESH_DIV > (1 << 20)) begin : g_bad_refresh_div
      $error("seg7_scan_controller: REFRESH_DIV out of range 2..2^20");
    end
    if (DEAD_CYCLES < 1 || DEAD_CYCLES >= REFRESH_DIV) begin : g_bad_dead_cycles
      $error("seg7_scan_controller: DEAD_CYCLES out of range 1..REFRESH_DIV-1");
    end
  endgenerate

  scan_state_t   r_state;
  scan_state_t   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_pend;
  logic [7:0]    r_disp;
  logic          r_rdy;
  logic          r_sel;
  logic          r_tick;
  logic [6:0]    r_seg;

  logic          w_slot_end;
  logic          w_dead_end;
  logic          w_show;
  logic          w_digit;
  logic          w_commit;
  logic          w_xfer;
  logic [3:0]    w_nibble;
  logic [6:0]    w_pattern;
  logic [6:0]    w_seg_nxt;

  always_comb begin
    w_slot_end  = (r_cnt == CNT_LAST);
    w_dead_end  = (r_cnt == DEAD_LAST);
    w_state_nxt = r_state;
    w_show      = 1'b0;
    w_digit     = 1'b0;
    case (r_state)
      SCAN_BLANK0: begin
        if (w_dead_end) w_state_nxt = SCAN_SHOW0;
      end
      SCAN_SHOW0: begin
        w_show = 1'b1;
        if (w_slot_end) w_state_nxt = SCAN_BLANK1;
      end
      SCAN_BLANK1: begin
        w_digit = 1'b1;
        if (w_dead_end) w_state_nxt = SCAN_SHOW1;
      end
      SCAN_SHOW1: begin
        w_show  = 1'b1;
        w_digit = 1'b1;
        if (w_slot_end) w_state_nxt = SCAN_BLANK0;
      end
      default: w_state_nxt = SCAN_BLANK0;
    endcase
  end

  assign w_commit  = (r_state == SCAN_BLANK0) && (r_cnt == '0);
  assign w_xfer    = value_valid && r_rdy;
  assign w_nibble  = w_digit ? r_disp[7:4] : r_disp[3:0];
  assign w_seg_nxt = (w_show && !blank[w_digit]) ? ~w_pattern : SEG_OFF;

  seg7_hex_decode u_hex (
    .i_nibble  (w_nibble),
    .o_pattern (w_pattern)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SCAN_BLANK0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_slot_end ? '0 : r_cnt + 1'b1;
    end
  end

  // r_rdy doubles as "pending empty"; the commit edge frees it so the
  // frame_tick cycle can already accept the next value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= 8'h00;
      r_disp <= 8'h00;
      r_rdy  <= 1'b1;
      r_seg  <= SEG_OFF;
      r_sel  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      if (w_commit && !r_rdy) r_disp <= r_pend;
      if (w_xfer) r_pend <= value_in;
      if (w_xfer) begin
        r_rdy <= 1'b0;
      end else if (w_commit) begin
        r_rdy <= 1'b1;
      end
      r_seg  <= w_seg_nxt;
      r_sel  <= w_digit;
      r_tick <= w_commit;
    end
  end

  assign {seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a} = r_seg;
  assign seg_select  = r_sel;
  assign frame_tick  = r_tick;
  assign value_ready = r_rdy;

endmodule
